// File: rtl/ex_co_arbiter_if.sv
// EX->CO packet type and the handshake bundle between the functional units and the arbiter.
package ex_co_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [5:0]  dest_preg;
    logic [31:0] result;
  } ex_co_packet_t;
endpackage

interface ex_co_if #(
  parameter int NUM_FU = 4
);
  import ex_co_pkg::*;

  logic [NUM_FU-1:0]          fu_valid;
  ex_co_packet_t [NUM_FU-1:0] fu_packet;
  logic [NUM_FU-1:0]          fu_ready;
  ex_co_packet_t              ex_co_packet;
  logic [NUM_FU-1:0]          fu_grant;

  // master drives results in and consumes the issued packet; slave is the arbiter
  modport master (
    output fu_valid,
    output fu_packet,
    input  fu_ready,
    input  ex_co_packet,
    input  fu_grant
  );

  modport slave (
    input  fu_valid,
    input  fu_packet,
    output fu_ready,
    output ex_co_packet,
    output fu_grant
  );
endinterface

// File: rtl/ex_co_arbiter.sv
// EX->CO transmit arbiter: per-FU result FIFOs drained one packet per cycle by a
// round-robin arbiter into a registered packet for the complete stage.
module ex_co_arbiter
  import ex_co_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   squash,
  ex_co_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [NUM_FU-1:0] ONE_HOT0 = {{(NUM_FU-1){1'b0}}, 1'b1};

  ex_co_packet_t     mem_r   [NUM_FU][DEPTH];
  logic [CNT_W-1:0]  count_r [NUM_FU];
  logic [PTR_W-1:0]  head_r  [NUM_FU];
  logic [PTR_W-1:0]  tail_r  [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr_r;
  ex_co_packet_t     out_pkt_r;
  logic [NUM_FU-1:0] grant_r;

  logic [NUM_FU-1:0] ready_s;
  logic [NUM_FU-1:0] nonempty_s;
  logic [NUM_FU-1:0] push_s;
  logic [NUM_FU-1:0] pop_s;
  logic              flush_s;
  logic              grant_valid_s;
  logic [IDX_W-1:0]  grant_idx_s;
  ex_co_packet_t     next_pkt_s;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int offset);
    int sum;
    sum = (base + offset) % NUM_FU;
    return IDX_W'(sum);
  endfunction

  assign flush_s = reset | squash;

  // FIFO status decoded from registered counts only; a pop never feeds back into ready
  always_comb begin
    ready_s    = '0;
    nonempty_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready_s[i]    = (count_r[i] != FULL_CNT);
      nonempty_s[i] = (count_r[i] != '0);
    end
  end

  assign push_s = bus.fu_valid & ready_s & {NUM_FU{~flush_s}};

  // Round-robin search from rr_ptr_r; scanning offsets high-to-low lets the nearest candidate win
  always_comb begin
    grant_idx_s   = '0;
    grant_valid_s = |nonempty_s;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      grant_idx_s = nonempty_s[wrap_idx(int'(rr_ptr_r), k)] ? wrap_idx(int'(rr_ptr_r), k)
                                                           : grant_idx_s;
    end
  end

  // Pop decode plus the outgoing packet with its valid bit forced on
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop_s[i] = grant_valid_s && (grant_idx_s == IDX_W'(i)) && !flush_s;
    end
    next_pkt_s       = mem_r[grant_idx_s][head_r[grant_idx_s]];
    next_pkt_s.valid = 1'b1;
  end

  // FIFO pointers and occupancy; reset and squash both empty every FIFO
  always_ff @(posedge clock) begin
    if (flush_s) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count_r[i] <= '0;
        head_r[i]  <= '0;
        tail_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push_s[i]) begin
          tail_r[i] <= tail_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          head_r[i] <= head_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because the counts gate every read
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_s[i]) begin
        mem_r[i][tail_r[i]] <= bus.fu_packet[i];
      end
    end
  end

  // Round-robin pointer: cleared by reset, held across a squash
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (!squash && grant_valid_s) begin
      rr_ptr_r <= wrap_idx(int'(grant_idx_s), 1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Registered packet and one-hot source toward the complete stage
  always_ff @(posedge clock) begin
    if (flush_s) begin
      out_pkt_r <= '0;
      grant_r   <= '0;
    end else if (grant_valid_s) begin
      out_pkt_r <= next_pkt_s;
      grant_r   <= ONE_HOT0 << grant_idx_s;
    end else begin
      out_pkt_r <= '0;
      grant_r   <= '0;
    end
  end

  assign bus.fu_ready     = ready_s;
  assign bus.ex_co_packet = out_pkt_r;
  assign bus.fu_grant     = grant_r;

endmodule

// File: tb/tb_ex_co_arbiter.sv
// Randomized scoreboard bench for ex_co_arbiter: a queue-based reference model predicts
// each edge's packet/grant and fu_ready; a separate monitor pops and compares.
module tb_ex_co_arbiter;
  import ex_co_pkg::*;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 2;

  typedef ex_co_packet_t [NUM_FU-1:0] pkt_vec_t;

  typedef struct {
    int                cyc;
    ex_co_packet_t     pkt;
    logic [NUM_FU-1:0] grant;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic squash;

  ex_co_if #(.NUM_FU(NUM_FU)) bus ();

  ex_co_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  exp_t          exp_q[$];
  ex_co_packet_t model_q[NUM_FU][$];
  int            model_rr = 0;
  int            n_checks = 0;
  int            n_fails  = 0;

  function automatic pkt_vec_t rand_pkts();
    pkt_vec_t p;
    for (int i = 0; i < NUM_FU; i++) begin
      p[i].valid     = 1'($urandom);
      p[i].rob_idx   = 5'($urandom);
      p[i].dest_preg = 6'($urandom);
      p[i].result    = $urandom;
    end
    return p;
  endfunction

  // One cycle of stimulus: check fu_ready, drive inputs, predict the next edge's output.
  task automatic step(input logic [NUM_FU-1:0] v, input pkt_vec_t pk, input logic r, input logic s);
    logic [NUM_FU-1:0] exp_ready;
    exp_t              e;
    int                g;
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_FU; i++) exp_ready[i] = (model_q[i].size() != DEPTH);
    n_checks++;
    if (bus.fu_ready !== exp_ready) begin
      n_fails++;
      $display("FAIL fu_ready cyc=%0d got=%b expected=%b", cyc_cnt, bus.fu_ready, exp_ready);
    end
    bus.fu_valid  = v;
    bus.fu_packet = pk;
    reset         = r;
    squash        = s;
    e.cyc   = cyc_cnt + 1;
    e.pkt   = '0;
    e.grant = '0;
    if (r || s) begin
      for (int i = 0; i < NUM_FU; i++) model_q[i].delete();
      if (r) model_rr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NUM_FU; k++) begin
        if (g < 0 && model_q[(model_rr + k) % NUM_FU].size() > 0) g = (model_rr + k) % NUM_FU;
      end
      if (g >= 0) begin
        e.pkt       = model_q[g].pop_front();
        e.pkt.valid = 1'b1;
        e.grant[g]  = 1'b1;
        model_rr    = (g + 1) % NUM_FU;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (v[i] && exp_ready[i]) model_q[i].push_back(pk[i]);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, rand_pkts(), 1'b0, 1'b0);
  endtask

  // Monitor: compares every edge whose prediction is due against the registered outputs
  initial begin
    forever begin
      exp_t e;
      @(posedge clock);
      #3;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.ex_co_packet !== e.pkt || bus.fu_grant !== e.grant) begin
          n_fails++;
          $display("FAIL out_pkt cyc=%0d got v=%b rob=%0d dst=%0d res=%h grant=%b expected v=%b rob=%0d dst=%0d res=%h grant=%b",
                   e.cyc, bus.ex_co_packet.valid, bus.ex_co_packet.rob_idx, bus.ex_co_packet.dest_preg,
                   bus.ex_co_packet.result, bus.fu_grant, e.pkt.valid, e.pkt.rob_idx, e.pkt.dest_preg,
                   e.pkt.result, e.grant);
        end
      end
    end
  end

  initial begin
    pkt_vec_t pv;
    int       wait_cnt;
    bus.fu_valid  = '1;
    bus.fu_packet = '0;
    reset         = 1'b1;
    squash        = 1'b0;

    // reset held with every FU valid: nothing may be retained
    step(4'hF, rand_pkts(), 1'b1, 1'b0);
    step(4'hF, rand_pkts(), 1'b1, 1'b0);
    idle(3);

    // single ALU result
    pv = rand_pkts();
    pv[0] = '{valid: 1'b1, rob_idx: 5'd3, dest_preg: 6'd5, result: 32'hDEAD_BEEF};
    step(4'b0001, pv, 1'b0, 1'b0);
    idle(2);

    // four-way contention from RR pointer 0
    step('0, rand_pkts(), 1'b1, 1'b0);
    step(4'hF, rand_pkts(), 1'b0, 1'b0);
    idle(5);

    // sustained pressure on every FU: FIFOs fill, full FIFOs get popped
    repeat (24) step(4'hF, rand_pkts(), 1'b0, 1'b0);
    idle(10);

    // squash with three buffered results and a push on the squash edge
    step(4'b1110, rand_pkts(), 1'b0, 1'b0);
    step(4'b0001, rand_pkts(), 1'b0, 1'b1);
    idle(3);
    step(4'hF, rand_pkts(), 1'b0, 1'b0);
    idle(5);

    // mid-operation reset: same, and RR restarts at FU0
    step(4'b1110, rand_pkts(), 1'b0, 1'b0);
    step(4'b0001, rand_pkts(), 1'b1, 1'b0);
    idle(3);
    step(4'hF, rand_pkts(), 1'b0, 1'b0);
    idle(5);

    // random traffic with occasional squash and reset
    repeat (400) begin
      step(NUM_FU'($urandom), rand_pkts(),
           1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 39) == 0));
    end
    idle(10);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 5) begin
      @(posedge clock);
      wait_cnt++;
    end
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
